// File: rtl/button_reader.sv
// Debounced push-button reader: press/release strobes, press counter, optional long-press detect.
// Define BUTTON_READER_LONG_PRESS_EN to build the hold counter, LONG_HELD state and long_press_pulse.
module button_reader #(
  parameter int unsigned DEBOUNCE_CYCLES   = 270000,
  parameter int unsigned LONG_PRESS_CYCLES = 27000000,
  parameter bit          ACTIVE_LOW        = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_in,
  output logic       btn_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_press_pulse,
  output logic [7:0] press_count
);

  localparam int unsigned   DB_W     = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic          SYNC_RST = ACTIVE_LOW;

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("button_reader: DEBOUNCE_CYCLES must be at least 2");
  end
  if (LONG_PRESS_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_long_press
    $error("button_reader: LONG_PRESS_CYCLES must exceed DEBOUNCE_CYCLES");
  end

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HELD      = 2'd1,
    LONG_HELD = 2'd2
  } state_e;

  logic            sync1_q, sync2_q;
  logic            sample_c;
  logic            level_q, level_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            accept_c, press_c, release_c;
  state_e          state_q;

  // Two-flop synchronizer; resets to the not-pressed pin level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= SYNC_RST;
      sync2_q <= SYNC_RST;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
    end
  end

  assign sample_c = sync2_q ^ ACTIVE_LOW;

  // A level change is accepted on the DEBOUNCE_CYCLES-th consecutive differing sample.
  always_comb begin
    level_d  = level_q;
    db_cnt_d = '0;
    accept_c = 1'b0;
    if (sample_c != level_q) begin
      if (db_cnt_q == DB_LAST) begin
        accept_c = 1'b1;
        level_d  = ~level_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  assign press_c   = accept_c & ~level_q;
  assign release_c = accept_c & level_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level_q       <= 1'b0;
      db_cnt_q      <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      press_count   <= 8'd0;
    end else begin
      level_q       <= level_d;
      db_cnt_q      <= db_cnt_d;
      press_pulse   <= press_c;
      release_pulse <= release_c;
      if (press_c) begin
        press_count <= press_count + 8'd1;
      end
    end
  end

  assign btn_level = level_q;

`ifdef BUTTON_READER_LONG_PRESS_EN
  localparam int unsigned       HOLD_W    = $clog2(LONG_PRESS_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

  logic [HOLD_W-1:0] hold_q;
  logic              long_q;

  // Press FSM; a release on the long-press edge takes priority.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      long_q  <= 1'b0;
    end else begin
      long_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (press_c) begin
            state_q <= HELD;
            hold_q  <= '0;
          end
        end
        HELD: begin
          if (release_c) begin
            state_q <= IDLE;
          end else if (hold_q == HOLD_LAST) begin
            state_q <= LONG_HELD;
            long_q  <= 1'b1;
          end else begin
            hold_q <= hold_q + HOLD_W'(1);
          end
        end
        LONG_HELD: begin
          if (release_c) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign long_press_pulse = long_q;
`else
  // Press FSM without long-press tracking.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE:    if (press_c)   state_q <= HELD;
        HELD:    if (release_c) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign long_press_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_button_reader.sv
// Randomized scoreboard bench for button_reader (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20, ACTIVE_LOW=1).
module tb_button_reader;

  localparam int DB = 4;
  localparam int LP = 20;

  localparam int K_PRESS   = 0;
  localparam int K_RELEASE = 1;
  localparam int K_LONG    = 2;

  typedef struct {
    int kind;
    int cyc;
    int cnt;
  } ev_t;

  logic       clk;
  logic       rst_n;
  logic       btn_in;
  logic       btn_level;
  logic       press_pulse;
  logic       release_pulse;
  logic       long_press_pulse;
  logic [7:0] press_count;

  int  n_chk  = 0;
  int  n_fail = 0;
  int  cyc    = 0;
  ev_t exp_q[$];

  bit m_s1, m_s2, m_lvl, m_held;
  int m_run, m_cnt, m_press_cyc;

  button_reader #(
    .DEBOUNCE_CYCLES  (DB),
    .LONG_PRESS_CYCLES(LP),
    .ACTIVE_LOW       (1'b1)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .btn_in          (btn_in),
    .btn_level       (btn_level),
    .press_pulse     (press_pulse),
    .release_pulse   (release_pulse),
    .long_press_pulse(long_press_pulse),
    .press_count     (press_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void push_ev(input int kind);
    ev_t e;
    e.kind = kind;
    e.cyc  = cyc;
    e.cnt  = m_cnt;
    exp_q.push_back(e);
  endfunction

  // Reference model: time-based view of the debounce and press rules.
  always @(posedge clk) begin : model
    bit samp;
    bit toggled;
    cyc++;
    toggled = 1'b0;
    if (!rst_n) begin
      m_s1 = 1'b0; m_s2 = 1'b0; m_lvl = 1'b0; m_held = 1'b0;
      m_run = 0; m_cnt = 0;
    end else begin
      samp = m_s2;
      m_s2 = m_s1;
      m_s1 = (btn_in == 1'b0);
      if (samp != m_lvl) m_run++;
      else m_run = 0;
      if (m_run == DB) begin
        m_run   = 0;
        m_lvl   = ~m_lvl;
        toggled = 1'b1;
        if (m_lvl) begin
          m_cnt       = (m_cnt + 1) % 256;
          m_press_cyc = cyc;
          m_held      = 1'b1;
          push_ev(K_PRESS);
        end else begin
          m_held = 1'b0;
          push_ev(K_RELEASE);
        end
      end
`ifdef BUTTON_READER_LONG_PRESS_EN
      if (!toggled && m_held && (cyc - m_press_cyc == LP)) push_ev(K_LONG);
`endif
    end
  end

  // Monitor: level/count every cycle, pulses matched against the expected-event queue.
  always @(negedge clk) begin : monitor
    logic [2:0] p;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      n_chk++;
      n_fail++;
      $display("FAIL missing_pulse: kind %0d never seen, expected at cycle %0d (now %0d)",
               exp_q[0].kind, exp_q[0].cyc, cyc);
      void'(exp_q.pop_front());
    end
    chk("btn_level", int'(btn_level), int'(m_lvl));
    chk("press_count", int'(press_count), m_cnt);
    p = {long_press_pulse, release_pulse, press_pulse};
    for (int k = 0; k < 3; k++) begin
      if (p[k]) begin
        n_chk++;
        if (exp_q.size() > 0 && exp_q[0].kind == k && exp_q[0].cyc == cyc) begin
          if (k == K_PRESS) chk("press_count_at_pulse", int'(press_count), exp_q[0].cnt);
          void'(exp_q.pop_front());
        end else begin
          n_fail++;
          $display("FAIL unexpected_pulse: kind %0d seen at cycle %0d, expected none", k, cyc);
        end
      end
    end
  end

  task automatic step(input logic b, input int n);
    btn_in = b;
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input logic b, input int n);
    rst_n = 1'b0;
    step(b, n);
    rst_n = 1'b1;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    rst_n  = 1'b0;
    btn_in = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_btn_level", int'(btn_level), 0);
    chk("reset_press_pulse", int'(press_pulse), 0);
    chk("reset_release_pulse", int'(release_pulse), 0);
    chk("reset_long_pulse", int'(long_press_pulse), 0);
    chk("reset_press_count", int'(press_count), 0);
    rst_n = 1'b1;

    step(1'b0, 12);
    chk("first_press_count", int'(press_count), 1);
    step(1'b1, 12);

    // Short glitches, then a glitch exactly at the acceptance threshold.
    step(1'b0, 3);
    step(1'b1, 10);
    step(1'b0, 1);
    step(1'b1, 10);
    step(1'b0, 4);
    step(1'b1, 12);

    // Long hold, then releases landing around the long-press edge.
    step(1'b0, 36);
    step(1'b1, 12);
    step(1'b0, 19);
    step(1'b1, 12);
    step(1'b0, 20);
    step(1'b1, 12);
    step(1'b0, 21);
    step(1'b1, 12);

    // Counter wrap from a clean start.
    do_reset(1'b1, 2);
    for (int i = 0; i < 257; i++) begin
      step(1'b0, 6);
      step(1'b1, 6);
    end
    chk("wrap_press_count", int'(press_count), 1);

    // Reset while held; button kept pressed through reset release.
    step(1'b0, 12);
    rst_n = 1'b0;
    step(1'b0, 2);
    chk("midpress_rst_level", int'(btn_level), 0);
    chk("midpress_rst_count", int'(press_count), 0);
    chk("midpress_rst_release", int'(release_pulse), 0);
    rst_n = 1'b1;
    step(1'b0, 12);
    chk("post_rst_press_count", int'(press_count), 1);
    step(1'b1, 12);

    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 24) == 0) do_reset(1'(btn_in), $urandom_range(1, 3));
      step(1'($urandom_range(0, 1)), $urandom_range(1, 32));
    end

    step(1'b1, 12);
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/button_reader.md
BUTTON_READER -- requirements
Module: button_reader

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 270000, meaning consecutive stable cycles needed to accept a level change (10 ms at 27 MHz); legal range is 2 or more.
REQ-002 The block SHALL have parameter LONG_PRESS_CYCLES, default 27000000, meaning cycles a press must be held to flag a long press (1 s at 27 MHz); it must be greater than DEBOUNCE_CYCLES.
REQ-003 The block SHALL have parameter ACTIVE_LOW, default 1, meaning btn_in reads 0 when pressed if set to 1, and 1 when pressed if set to 0.
REQ-004 The block SHALL have port clk, input, 1 bit: the single 27 MHz clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: a synchronous, active-low reset.
REQ-006 The block SHALL have port btn_in, input, 1 bit: the raw asynchronous push-button pin.
REQ-007 The block SHALL have port btn_level, output, 1 bit: the debounced level, 1 = pressed.
REQ-008 The block SHALL have port press_pulse, output, 1 bit: a 1-cycle strobe on each accepted press.
REQ-009 The block SHALL have port release_pulse, output, 1 bit: a 1-cycle strobe on each accepted release.
REQ-010 The block SHALL have port long_press_pulse, output, 1 bit: a 1-cycle strobe when a press reaches the long-press duration.
REQ-011 The block SHALL have port press_count, output, 8 bits: the count of accepted presses.

Function
REQ-012 The block SHALL pass btn_in through a 2-flop synchronizer, then normalize it to "pressed" = 1 using ACTIVE_LOW.
REQ-013 The debounce counter SHALL increment each cycle the normalized sample differs from btn_level, and SHALL clear to 0 on any cycle the sample equals btn_level.
REQ-014 When the debounce counter reaches DEBOUNCE_CYCLES-1 with the sample still differing, btn_level SHALL toggle on the next edge and the counter SHALL clear.
REQ-015 Latency from a clean btn_in edge to the btn_level change SHALL be exactly 2 + DEBOUNCE_CYCLES cycles.
REQ-016 A glitch held for fewer than DEBOUNCE_CYCLES synchronized cycles SHALL produce no change on any output.
REQ-017 The FSM SHALL have the states IDLE, HELD, LONG_HELD.
- IDLE -> HELD on an accepted press.
- HELD -> LONG_HELD when the hold counter reaches LONG_PRESS_CYCLES-1.
- HELD or LONG_HELD -> IDLE on an accepted release.
REQ-018 press_pulse SHALL be high in the same cycle btn_level first reads 1, and release_pulse in the same cycle btn_level first reads 0; both SHALL be exactly 1 cycle long.
REQ-019 The hold counter SHALL start at 0 in the first cycle of HELD and increment every cycle while in HELD; long_press_pulse SHALL assert for 1 cycle on the HELD -> LONG_HELD transition, at most once per press.
REQ-020 If a release is accepted on the same cycle the hold counter would reach LONG_PRESS_CYCLES-1, the release SHALL win: the FSM goes to IDLE and no long_press_pulse is issued.
REQ-021 press_count SHALL increment on each press_pulse and wrap from 255 to 0 with no saturation and no flag.
REQ-022 All outputs SHALL be registered, with no combinational path from btn_in.

Reset
REQ-023 While rst_n = 0 at a clk edge, the block SHALL clear these to 0: synchronizer flops (to the not-pressed value), btn_level, all pulses, press_count, and the debounce and hold counters; the FSM SHALL go to IDLE.
REQ-024 A reset asserted mid-press SHALL abort the press with no release_pulse issued.
REQ-025 If the button is held through reset release, the block SHALL report it as a new press after 2 + DEBOUNCE_CYCLES cycles.

Configuration
REQ-026 With macro BUTTON_READER_LONG_PRESS_EN defined, the LONG_HELD state, the hold counter and long_press_pulse SHALL be implemented as specified above.
REQ-027 Without BUTTON_READER_LONG_PRESS_EN, the hold counter and LONG_HELD state SHALL be omitted, long_press_pulse SHALL be tied to 0, and all other behaviour SHALL be unchanged.

Verification (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20, ACTIVE_LOW=1)
REQ-028 Scenario: reset, then btn_in driven 0 and held -> btn_level rises 6 cycles later, press_pulse high for 1 cycle, press_count = 1.
REQ-029 Scenario: btn_in low for 3 cycles, then high -> no output changes and press_count remains 0.
REQ-030 Scenario: press held for 30 cycles after acceptance with the macro defined -> exactly one long_press_pulse, 20 cycles after press_pulse; without the macro, long_press_pulse stays 0.
REQ-031 Scenario: release accepted on the cycle the hold counter reaches 19 -> release_pulse is issued and long_press_pulse is never issued.
REQ-032 Scenario: 257 clean presses -> press_count = 1 after the wrap.
REQ-033 Scenario: rst_n pulsed low while HELD -> all outputs are 0 and no release_pulse; with btn_in still low, a new press_pulse occurs 6 cycles after reset release.
